pwm_ctrl: RTL and testbench
===========================

PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4, number of PWM channels.
- CNT_W, default 8, period counter width.
- CLK_DIV, default 4, clk cycles per counter tick (legal range 1..65535).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel enable, one bit per channel-select CSR.
- duty  in  NUM_CH*CNT_W  per-channel duty; channel i at bits [i*CNT_W +: CNT_W].
- pwm_out  out  NUM_CH  registered PWM outputs, also fed to the PWM_OUTn CSR inputs.
- tick  out  1  one-clk pulse on each period-counter advance.
- period_start  out  1  one-clk pulse when the counter wraps from 2^CNT_W-1 to 0.
- ch_active  out  NUM_CH  channel i is in state RUN.
REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 Prescaler: counter 0..CLK_DIV-1, free-running after reset; tick SHALL be 1 on the clk where prescaler == CLK_DIV-1, and the prescaler then returns to 0.
REQ-005 CLK_DIV == 1: tick SHALL be 1 on every clk.
REQ-006 Period counter cnt (CNT_W bits) SHALL increment modulo 2^CNT_W on tick only; period = 2^CNT_W ticks = 256*CLK_DIV clk at defaults.
REQ-007 period_start SHALL equal tick AND (cnt == 2^CNT_W-1), registered with tick.
REQ-008 Per-channel FSM states: OFF, ARMED, RUN.
- OFF to ARMED when ch_en[i] = 1.
- ARMED to RUN on period_start.
- ARMED or RUN to OFF when ch_en[i] = 0; this has priority over all other transitions.
REQ-009 On the ARMED-to-RUN transition, and on every period_start while in RUN, duty_sh[i] SHALL load duty[i]. duty changes at any other time SHALL take effect only at the next period_start (no glitching mid-period).
REQ-010 In RUN, pwm_out[i] SHALL be registered (cnt < duty_sh[i]) and lag cnt by exactly one clk. In OFF and ARMED, pwm_out[i] SHALL be 0.
REQ-011 Duty boundaries:
- duty 0: output constant 0.
- duty 2^CNT_W-1: output high 255 ticks, low 1 tick per period.
- There SHALL be no 100% setting.
REQ-012 ch_en[i] rising on the same clk as period_start: the channel SHALL enter ARMED only and go to RUN at the following period_start.
REQ-013 ch_en[i] falling while pwm_out[i] = 1: pwm_out[i] SHALL be 0 on the next clk and duty_sh[i] SHALL clear to 0.
REQ-014 Channels SHALL be fully independent and share only the prescaler and cnt.
REQ-015 Prescaler and cnt SHALL run regardless of ch_en.

Reset
REQ-016 While rst_n = 0, the following SHALL be 0, taking effect asynchronously: prescaler, cnt, every duty_sh, pwm_out, tick, period_start, ch_active. All FSMs SHALL be OFF.
REQ-017 After rst_n deasserts, the first tick SHALL occur CLK_DIV clk later.
REQ-018 Reset asserted mid-period SHALL abort the period with no residual output pulse.

Structure
REQ-019 Shared package pwm_pkg SHALL hold:
- the NUM_CH and CNT_W defaults;
- the channel-state enum (OFF=2'd0, ARMED=2'd1, RUN=2'd2);
- the wrap constant CNT_MAX = 2^CNT_W-1.
REQ-020 The top SHALL contain the prescaler, cnt and pulse generation.
REQ-021 Sub-module pwm_chan (FSM, duty_sh, compare, output flop) SHALL be instantiated NUM_CH times with a generate loop.

Verification (defaults: CLK_DIV=4, period 1024 clk)
REQ-022 ch_en=0001, duty0=64 -> after the first period_start, pwm_out[0] high 256 clk and low 768 clk, repeating; other outputs 0.
REQ-023 duty0=0 -> pwm_out[0] constant 0 while ch_active[0]=1. duty0=255 -> high 1020 clk, low 4 clk per period.
REQ-024 duty0 changed 64 -> 128 at cnt=10 -> current period high 256 clk; next period high 512 clk.
REQ-025 ch_en[0] cleared at cnt=20 with duty 64 -> pwm_out[0]=0 next clk, state OFF. Re-enabled on a period_start clk -> ARMED, RUN one full period later.
REQ-026 rst_n pulsed low at cnt=100 with 4 channels running -> all outputs 0 immediately, cnt=0; first tick 4 clk after release.
REQ-027 All 4 channels enabled, duties 0/85/170/255 -> each high-time equals 4*duty clk, with all channels aligned to the same period_start.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM types and constants: channel FSM states, default widths, wrap value.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } ch_state_t;

    function automatic int cnt_max_of(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max_of(CNT_W_DEF);

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: OFF/ARMED/RUN FSM, period-latched duty, registered compare output.
// Latency: pwm lags cnt by one clk; dropping en forces pwm low on the next clk.
// Backpressure: none, outputs are free-running.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] cnt,
    input  logic             period_start,
    output logic             pwm,
    output logic             active
);

    ch_state_t        state;
    logic [CNT_W-1:0] duty_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OFF;
            duty_sh <= '0;
            pwm     <= 1'b0;
            active  <= 1'b0;
        end else if (!en) begin
            // disable wins over every other transition and aborts the pulse
            state   <= OFF;
            duty_sh <= '0;
            pwm     <= 1'b0;
            active  <= 1'b0;
        end else begin
            pwm <= (state == RUN) && (cnt < duty_sh);
            case (state)
                OFF: begin
                    state  <= ARMED;
                    active <= 1'b0;
                end
                ARMED: begin
                    if (period_start) begin
                        state   <= RUN;
                        duty_sh <= duty;
                        active  <= 1'b1;
                    end
                end
                RUN: begin
                    if (period_start) begin
                        duty_sh <= duty;
                    end
                end
                default: begin
                    state  <= OFF;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// Multi-channel PWM: shared prescaler and period counter feeding NUM_CH channels.
// Latency: tick/period_start registered; pwm_out lags the period counter by one clk.
// Backpressure: none, counters free-run regardless of channel enables.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    tick,
    output logic                    period_start,
    output logic [NUM_CH-1:0]       ch_active
);

    localparam logic [15:0]      PRESC_TOP = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(cnt_max_of(CNT_W));

    logic [15:0]      presc;
    logic [15:0]      presc_d;
    logic             tick_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             ps_d;

    // Pulses are computed from next-state values so they line up with the
    // cycle in which the prescaler sits at its top value.
    always_comb begin
        presc_d = (presc == PRESC_TOP) ? 16'd0 : presc + 16'd1;
        tick_d  = (presc_d == PRESC_TOP);
        cnt_d   = tick ? cnt + CNT_W'(1) : cnt;
        ps_d    = tick_d && (cnt_d == CNT_TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            tick         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc        <= presc_d;
            cnt          <= cnt_d;
            tick         <= tick_d;
            period_start <= ps_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (ch_en[i]),
            .duty         (duty[i*CNT_W +: CNT_W]),
            .cnt          (cnt),
            .period_start (period_start),
            .pwm          (pwm_out[i]),
            .active       (ch_active[i])
        );
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: cycle-by-cycle reference model plus directed high-time checks.
// Latency: model predicts each output for the cycle after every rising edge.
// Backpressure: n/a.
module tb_pwm_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int D   = 4;
    localparam int P   = 256 * D;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   ch_en = '0;
    logic [NCH*CW-1:0] duty = '0;
    logic [NCH-1:0]   pwm_out;
    logic             tick;
    logic             period_start;
    logic [NCH-1:0]   ch_active;

    int n_vec = 0;
    int n_err = 0;
    int hi[2][NCH];

    always #5 clk = ~clk;

    pwm_ctrl #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .CLK_DIV (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .tick         (tick),
        .period_start (period_start),
        .ch_active    (ch_active)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle k counts rising edges since reset release.
    int             k;
    int             cnt_prev;
    int             en_since[NCH];
    int             lat[NCH];
    bit             run_prev[NCH];
    bit             run_now;
    logic [NCH-1:0] en_s;
    logic [NCH*CW-1:0] du_s;
    logic           rs;
    logic [NCH-1:0] exp_pwm;
    logic [NCH-1:0] exp_act;

    always begin
        @(posedge clk);
        en_s = ch_en;
        du_s = duty;
        rs   = rst_n;
        #1;
        if (!rs) begin
            k        = 0;
            cnt_prev = 0;
            for (int i = 0; i < NCH; i++) begin
                en_since[i] = -1;
                lat[i]      = 0;
                run_prev[i] = 1'b0;
            end
            chk("reset_tick", int'(tick), 0);
            chk("reset_period_start", int'(period_start), 0);
            chk("reset_ch_active", int'(ch_active), 0);
            chk("reset_pwm_out", int'(pwm_out), 0);
        end else begin
            k++;
            for (int i = 0; i < NCH; i++) begin
                exp_pwm[i] = run_prev[i] && en_s[i] && (cnt_prev < lat[i]);
                if (!en_s[i])
                    en_since[i] = -1;
                else if (en_since[i] < 0)
                    en_since[i] = k;
                // running once a period boundary has passed since enabling
                run_now = (en_since[i] >= 0) && ((en_since[i] / P) * P + P - 1 < k);
                if (!run_now)
                    lat[i] = 0;
                else if ((k - 1) % P == P - 1)
                    lat[i] = int'(du_s[i*CW +: CW]);
                exp_act[i]  = run_now;
                run_prev[i] = run_now;
            end
            cnt_prev = (k / D) % 256;
            chk("tick", int'(tick), (k % D == D - 1) ? 1 : 0);
            chk("period_start", int'(period_start), (k % P == P - 1) ? 1 : 0);
            chk("ch_active", int'(ch_active), int'(exp_act));
            chk("pwm_out", int'(pwm_out), int'(exp_pwm));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ps();
        for (int n = 0; n < 2 * P + 8; n++) begin
            cyc();
            if (period_start) return;
        end
        chk("period_start_timeout", int'(period_start), 1);
    endtask

    // High cycles per channel over the two periods following the next period_start.
    task automatic measure(input int chg_j, input logic [7:0] chg_v);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NCH; i++)
                hi[p][i] = 0;
        wait_ps();
        cyc();
        for (int j = 0; j < 2 * P; j++) begin
            cyc();
            for (int i = 0; i < NCH; i++)
                hi[j / P][i] += int'(pwm_out[i]);
            if (j == chg_j) duty[7:0] = chg_v;
        end
    endtask

    task automatic first_ticks(input string tag);
        cyc(); chk({tag, "_tick_c1"}, int'(tick), 0);
        cyc(); chk({tag, "_tick_c2"}, int'(tick), 0);
        cyc(); chk({tag, "_tick_c3"}, int'(tick), 1);
    endtask

    initial begin
        int c;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_ch_active", int'(ch_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        first_ticks("release");

        ch_en     = 4'b0001;
        duty[7:0] = 8'd64;
        measure(-1, 8'd0);
        chk("duty64_hi_p0", hi[0][0], 256);
        chk("duty64_hi_p1", hi[1][0], 256);
        chk("duty64_ch1_hi", hi[0][1], 0);
        chk("duty64_ch3_hi", hi[1][3], 0);
        chk("duty64_active", int'(ch_active), 1);

        duty[7:0] = 8'd0;
        measure(-1, 8'd0);
        chk("duty0_hi", hi[0][0] + hi[1][0], 0);
        chk("duty0_active", int'(ch_active[0]), 1);

        duty[7:0] = 8'd255;
        measure(-1, 8'd0);
        chk("duty255_hi_p0", hi[0][0], 1020);
        chk("duty255_hi_p1", hi[1][0], 1020);

        duty[7:0] = 8'd64;
        measure(39, 8'd128);
        chk("duty_chg_cur_period", hi[0][0], 256);
        chk("duty_chg_next_period", hi[1][0], 512);

        duty[7:0] = 8'd64;
        wait_ps();
        repeat (81) cyc();
        chk("pre_disable_pwm", int'(pwm_out[0]), 1);
        ch_en[0] = 1'b0;
        cyc();
        chk("disable_pwm", int'(pwm_out[0]), 0);
        chk("disable_active", int'(ch_active[0]), 0);
        wait_ps();
        ch_en[0] = 1'b1;
        repeat (P) cyc();
        chk("reenable_armed", int'(ch_active[0]), 0);
        cyc();
        chk("reenable_run", int'(ch_active[0]), 1);

        ch_en = 4'b1111;
        duty  = {8'd255, 8'd170, 8'd85, 8'd0};
        measure(-1, 8'd0);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("multi_ch0_p%0d", p), hi[p][0], 0);
            chk($sformatf("multi_ch1_p%0d", p), hi[p][1], 340);
            chk($sformatf("multi_ch2_p%0d", p), hi[p][2], 680);
            chk($sformatf("multi_ch3_p%0d", p), hi[p][3], 1020);
        end

        wait_ps();
        repeat (401) cyc();
        chk("pre_reset_active", int'(ch_active), 15);
        rst_n = 1'b0;
        #1;
        chk("midreset_pwm_out", int'(pwm_out), 0);
        chk("midreset_tick", int'(tick), 0);
        chk("midreset_period_start", int'(period_start), 0);
        chk("midreset_ch_active", int'(ch_active), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        first_ticks("midreset");

        for (int n = 0; n < 6000; n++) begin
            cyc();
            if ($urandom_range(63) == 0) begin
                c = int'($urandom_range(NCH - 1));
                ch_en[c] = ~ch_en[c];
            end
            if ($urandom_range(15) == 0) begin
                c = int'($urandom_range(NCH - 1));
                r = int'($urandom_range(3));
                duty[c*CW +: CW] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(255));
            end
            if (n == 3000) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
